// File: rtl/la_xnorbist_pkg.sv
// Shared types and constants for the la_xnorbist XNOR-bank self-test sequencer.
package la_xnorbist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int LFSR_W = 32;
  localparam int TAP_A  = 32;
  localparam int TAP_B  = 22;
  localparam int TAP_C  = 2;
  localparam int TAP_D  = 1;
  localparam logic [LFSR_W-1:0] LFSR_SEED = '0;

  // Bit p of each constant is the value driven on every cell for corner pattern p.
  localparam logic [3:0] CORNER_A = 4'b1100;
  localparam logic [3:0] CORNER_B = 4'b1010;

  localparam int ERR_W = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~(s[TAP_A-1] ^ s[TAP_B-1] ^ s[TAP_C-1] ^ s[TAP_D-1])};
  endfunction

endpackage

// File: rtl/la_xnorbist_lfsr.sv
// 32-bit Fibonacci XNOR LFSR; load reseeds and wins over step.
module la_xnorbist_lfsr
  import la_xnorbist_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)      lfsr_d = LFSR_SEED;
    else if (step) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/la_xnorbist.sv
// BIST sequencer for a bank of N XNOR cells: 4 corner patterns, then NPAT LFSR patterns.
// Optional first-failure capture (fail_idx/fail_vec) under LA_XNORBIST_FAILCAP_EN.
module la_xnorbist
  import la_xnorbist_pkg::*;
#(
  parameter int    N    = 8,
  parameter int    NPAT = 256,
  parameter string PROP = "DEFAULT"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N-1:0]     dut_a,
  output logic [N-1:0]     dut_b,
  input  logic [N-1:0]     dut_z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] errcnt
`ifdef LA_XNORBIST_FAILCAP_EN
  ,
  output logic [15:0]      fail_idx,
  output logic [N-1:0]     fail_vec
`endif
);

  localparam logic [16:0] P_LAST = 17'(NPAT + 3);

  state_e             state_q, state_d;
  logic [16:0]        p_q, p_d;
  logic [N-1:0]       a_q, a_d, b_q, b_d, exp_q, exp_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [ERR_W-1:0]   errcnt_q, errcnt_d;
  logic               mism;
  logic               lfsr_load, lfsr_step;
  logic [LFSR_W-1:0]  lfsr_q;
`ifdef LA_XNORBIST_FAILCAP_EN
  logic [16:0]        idx_q, idx_d;
  logic [15:0]        fail_idx_q, fail_idx_d;
  logic [N-1:0]       fail_vec_q, fail_vec_d;
`endif

  la_xnorbist_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .lfsr  (lfsr_q)
  );

  // A pattern is checked one edge after it is driven, giving the bank a full cycle to settle.
  assign mism = vld_q && (|(dut_z ^ exp_q));

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    a_d       = '0;
    b_d       = '0;
    vld_d     = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    busy_d    = (state_q == RUN) || (state_q == DRAIN);
    done_d    = (state_q == DONE);
    errcnt_d  = errcnt_q;
    if (mism && (errcnt_q != ERR_MAX)) errcnt_d = errcnt_q + 1'b1;
`ifdef LA_XNORBIST_FAILCAP_EN
    idx_d      = idx_q;
    fail_idx_d = fail_idx_q;
    fail_vec_d = fail_vec_q;
    if (mism && (errcnt_q == '0)) begin
      fail_idx_d = idx_q[15:0];
      fail_vec_d = dut_z ^ exp_q;
    end
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          p_d       = '0;
          lfsr_load = 1'b1;
        end
      end
      RUN: begin
        // Results are cleared here rather than on the entry edge so a restart keeps
        // errcnt/pass consistent with done during the one cycle done is visible.
        if (p_q == '0) begin
          errcnt_d = '0;
`ifdef LA_XNORBIST_FAILCAP_EN
          fail_idx_d = '0;
          fail_vec_d = '0;
`endif
        end
        if (p_q < 17'd4) begin
          a_d = {N{CORNER_A[p_q[1:0]]}};
          b_d = {N{CORNER_B[p_q[1:0]]}};
        end else begin
          a_d       = lfsr_q[N-1:0];
          b_d       = lfsr_q[LFSR_W-1 -: N];
          lfsr_step = 1'b1;
        end
        vld_d = 1'b1;
`ifdef LA_XNORBIST_FAILCAP_EN
        idx_d = p_q;
`endif
        p_d = p_q + 17'd1;
        if (p_q == P_LAST) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    exp_d = ~(a_d ^ b_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      p_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      exp_q    <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      errcnt_q <= '0;
`ifdef LA_XNORBIST_FAILCAP_EN
      idx_q      <= '0;
      fail_idx_q <= '0;
      fail_vec_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      a_q      <= a_d;
      b_q      <= b_d;
      exp_q    <= exp_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      errcnt_q <= errcnt_d;
`ifdef LA_XNORBIST_FAILCAP_EN
      idx_q      <= idx_d;
      fail_idx_q <= fail_idx_d;
      fail_vec_q <= fail_vec_d;
`endif
    end
  end

  assign dut_a  = a_q;
  assign dut_b  = b_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign errcnt = errcnt_q;
  assign pass   = done_q & (errcnt_q == '0);
`ifdef LA_XNORBIST_FAILCAP_EN
  assign fail_idx = fail_idx_q;
  assign fail_vec = fail_vec_q;
`endif

endmodule

// File: tb/tb_la_xnorbist.sv
// Self-checking bench for la_xnorbist: behavioural XNOR banks with injectable faults.
module tb_la_xnorbist;

  localparam int N      = 8;
  localparam int NPAT   = 16;
  localparam int NPAT_S = 65535;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } corner_t;

  typedef struct {
    int fault;
    bit mid_start;
    bit hold;
    bit exp_pass;
  } run_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic [7:0]  dut_a, dut_b, dut_z, a_s, b_s, z_s;
  logic        busy, done, pass, busy_s, done_s, pass_s;
  logic [15:0] errcnt, errcnt_s;
`ifdef LA_XNORBIST_FAILCAP_EN
  logic [15:0] fail_idx, fail_idx_s;
  logic [7:0]  fail_vec, fail_vec_s;
`endif

  int fault_sel = 0;
  int n_chk = 0;
  int n_pass = 0;
  corner_t corners[4];
  run_t    runs[4];

  always #5 clk = ~clk;

  // fault 1: cell 3 stuck-at-0; fault 2: every cell inverted
  function automatic logic [7:0] bank(input int f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      1:       return ~(a ^ b) & 8'hF7;
      2:       return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
  endfunction

  assign dut_z = bank(fault_sel, dut_a, dut_b);
  assign z_s   = a_s ^ b_s;

  la_xnorbist #(.N(N), .NPAT(NPAT), .PROP("DEFAULT")) u_dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dut_a  (dut_a),
    .dut_b  (dut_b),
    .dut_z  (dut_z),
    .busy   (busy),
    .done   (done),
    .pass   (pass),
    .errcnt (errcnt)
`ifdef LA_XNORBIST_FAILCAP_EN
    ,
    .fail_idx (fail_idx),
    .fail_vec (fail_vec)
`endif
  );

  la_xnorbist #(.N(N), .NPAT(NPAT_S), .PROP("DEFAULT")) u_sat (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .dut_a  (a_s),
    .dut_b  (b_s),
    .dut_z  (z_s),
    .busy   (busy_s),
    .done   (done_s),
    .pass   (pass_s),
    .errcnt (errcnt_s)
`ifdef LA_XNORBIST_FAILCAP_EN
    ,
    .fail_idx (fail_idx_s),
    .fail_vec (fail_vec_s)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " dut_a"},  32'(dut_a),  32'h0);
    chk({tag, " dut_b"},  32'(dut_b),  32'h0);
    chk({tag, " busy"},   32'(busy),   32'h0);
    chk({tag, " done"},   32'(done),   32'h0);
    chk({tag, " pass"},   32'(pass),   32'h0);
    chk({tag, " errcnt"}, 32'(errcnt), 32'h0);
  endtask

  task automatic run_once(input run_t r, input int id);
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [7:0]  ea, eb, fvec;
    logic [31:0] s;
    int          cnt, fidx, c;
    string       tag;
    tag = $sformatf("run%0d", id);
    fault_sel = r.fault;
    s = '0; cnt = 0; fidx = 0; fvec = '0;
    for (int p = 0; p < NPAT + 4; p++) begin
      if (p < 4) begin
        ea = corners[p].a; eb = corners[p].b;
      end else begin
        ea = s[7:0]; eb = s[31:24];
        s = ref_step(s);
      end
      qa.push_back(ea);
      qb.push_back(eb);
      if ((bank(r.fault, ea, eb) ^ ~(ea ^ eb)) != 8'h00) begin
        if (cnt == 0) begin
          fidx = p;
          fvec = bank(r.fault, ea, eb) ^ ~(ea ^ eb);
        end
        cnt++;
      end
    end
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); if (!r.hold) start = 1'b0;
    for (int k = 0; k < NPAT + 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("%s busy p%0d", tag, k), 32'(busy), 32'h1);
      chk($sformatf("%s dut_a p%0d", tag, k), 32'(dut_a), 32'(qa.pop_front()));
      chk($sformatf("%s dut_b p%0d", tag, k), 32'(dut_b), 32'(qb.pop_front()));
      if (r.mid_start && k == 1) start = 1'b1;
      if (r.mid_start && k == 2) start = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    chk({tag, " done early"}, 32'(done), 32'h0);
    @(posedge clk); @(negedge clk);
    chk({tag, " done"},   32'(done),   32'h1);
    chk({tag, " busy off"}, 32'(busy), 32'h0);
    chk({tag, " errcnt"}, 32'(errcnt), 32'(cnt));
    chk({tag, " pass"},   32'(pass),   32'(r.exp_pass));
`ifdef LA_XNORBIST_FAILCAP_EN
    chk({tag, " fail_idx"}, 32'(fail_idx), 32'(fidx));
    chk({tag, " fail_vec"}, 32'(fail_vec), 32'(fvec));
`endif
    if (r.hold) begin
      @(posedge clk); @(negedge clk);
      chk({tag, " restart done"},   32'(done),   32'h0);
      chk({tag, " restart busy"},   32'(busy),   32'h1);
      chk({tag, " restart errcnt"}, 32'(errcnt), 32'h0);
      start = 1'b0;
      c = 0;
      while (!done && c < NPAT + 12) begin
        @(posedge clk); @(negedge clk);
        c++;
      end
      chk({tag, " restart done"},    32'(done),   32'h1);
      chk({tag, " restart latency"}, 32'(c),      32'(NPAT + 5));
      chk({tag, " restart errcnt2"}, 32'(errcnt), 32'(cnt));
    end
  endtask

  initial begin
    int c;
    corners[0] = '{a: 8'h00, b: 8'h00};
    corners[1] = '{a: 8'h00, b: 8'hFF};
    corners[2] = '{a: 8'hFF, b: 8'h00};
    corners[3] = '{a: 8'hFF, b: 8'hFF};
    runs[0] = '{fault: 0, mid_start: 1'b0, hold: 1'b0, exp_pass: 1'b1};
    runs[1] = '{fault: 1, mid_start: 1'b0, hold: 1'b0, exp_pass: 1'b0};
    runs[2] = '{fault: 0, mid_start: 1'b1, hold: 1'b0, exp_pass: 1'b1};
    runs[3] = '{fault: 1, mid_start: 1'b0, hold: 1'b1, exp_pass: 1'b0};

    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("idle");

    for (int i = 0; i < 4; i++) run_once(runs[i], i);

    // reset pulsed at T+7 in the middle of a run
    fault_sel = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midrst busy before", 32'(busy), 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    #1 chk_idle("midrst async");
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("midrst idle");
    run_once(runs[0], 4);

    // saturation with every cell inverted
    @(negedge clk); start_s = 1'b1;
    @(posedge clk);
    @(negedge clk); start_s = 1'b0;
    c = 0;
    while (!done_s && c < NPAT_S + 20) begin
      @(posedge clk); @(negedge clk);
      c++;
    end
    chk("sat done",    32'(done_s),   32'h1);
    chk("sat latency", 32'(c),        32'(NPAT_S + 6));
    chk("sat errcnt",  32'(errcnt_s), 32'h0000FFFF);
    chk("sat pass",    32'(pass_s),   32'h0);
    chk("sat busy",    32'(busy_s),   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/la_xnorbist.md
# la_xnorbist

Built-in self-test sequencer for a bank of N two-input XNOR cells. It drives the bank's a/b inputs with four directed corner patterns followed by NPAT pseudo-random patterns from an XNOR-feedback LFSR. Each cell's z output is compared against the expected ~(a^b), and the mismatching patterns are counted. The block sits beside any la_xnor2 bank in the design and is started by a test controller or a scan/JTAG register.

## Interface
Parameters:
- N, 8: number of XNOR cells under test, 1..16.
- NPAT, 256: pseudo-random pattern count, 1..65535.
- PROP, "DEFAULT": implementation property, passed through.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-high reset.
- start  input  1  level-sampled start request.
- dut_a  output  N  stimulus to cell a inputs, registered.
- dut_b  output  N  stimulus to cell b inputs, registered.
- dut_z  input  N  cell z outputs.
- busy  output  1  test in progress.
- done  output  1  test complete, sticky.
- pass  output  1  done with zero errors.
- errcnt  output  16  mismatching-pattern count, saturating.

## Operation
- FSM states:
  - IDLE: on start=1, go to RUN.
  - RUN: advance pattern index p each cycle; when p is the last pattern (3+NPAT), go to DRAIN.
  - DRAIN: go to DONE.
  - DONE: on start=1, go to RUN (restart); otherwise hold.
- start is ignored in RUN and DRAIN.
- Patterns p=0..3 (all bits of the bank): (a,b) = (0,0), (0,1), (1,0), (1,1). Together these give every cell its full truth table.
- Patterns p≥4 come from a 32-bit Fibonacci XNOR LFSR, taps 32,22,2,1, seeded with 0.
  - The LFSR advances one step per random pattern.
  - dut_a = lfsr[N-1:0], dut_b = lfsr[31:32-N].
  - The all-ones lock-up state is unreachable from seed 0.
- Expected value: exp = ~(dut_a ^ dut_b), registered alongside the stimulus.
- Check: a pattern mismatches when (dut_z ^ exp) != 0.
  - errcnt increments by 1 per mismatching pattern, not per bit.
  - errcnt saturates at 16'hFFFF.
- On entry to RUN: errcnt, p and the LFSR are cleared/reseeded and done is cleared.
- pass = done & (errcnt == 0).
- In IDLE and DONE, dut_a and dut_b are driven to 0.

## Timing
- All outputs reset to 0: dut_a, dut_b, busy, done, pass, errcnt. FSM resets to IDLE, LFSR to seed 0.
- start sampled high at edge T: pattern 0 is on dut_a/dut_b after edge T+1, and busy=1 from T+1.
- Pattern p is driven for exactly one cycle. Its dut_z is compared at the following edge, which allows one full cycle of combinational settle through the bank.
- The last pattern is compared during DRAIN.
- done=1 and busy=0 after edge T+NPAT+6. Total latency is 4+NPAT+2 cycles after start.
- Reset asserted mid-run: asynchronous return to IDLE with all outputs 0. No partial result is retained.
- start held high through DONE: an immediate restart one cycle after done rises. done is visible for one cycle.

## Configuration
- LA_XNORBIST_FAILCAP_EN defined:
  - Adds outputs fail_idx (16 bits) and fail_vec (N bits).
  - Together they capture the pattern index and the (dut_z ^ exp) vector of the first mismatch in a run.
  - Both are cleared on entry to RUN, held after capture, and 0 if no error occurs.
- Undefined: these ports and registers do not exist. Behaviour is otherwise identical.

## Structure
- Package la_xnorbist_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - LFSR width, tap positions and seed;
  - the four corner-pattern constants;
  - the errcnt width and saturation value.
- Sub-module la_xnorbist_lfsr: 32-bit XNOR LFSR with load (seed) and step enables. It is the only natural sub-module.

## Test plan
- Fault-free behavioural XNOR bank, N=8, NPAT=16, start at T: done=1 at T+22, pass=1, errcnt=0. dut_a/dut_b show 00,FF crosses for p=0..3 and then match the reference LFSR model.
- Bank with bit 3 stuck-at-0, N=8, NPAT=16: errcnt equals the model's count of patterns with a[3]==b[3] (≥2, from corner patterns 0 and 3), pass=0. With FAILCAP: fail_idx=0, fail_vec=8'h08.
- Every bit inverted, NPAT=65535: errcnt saturates at 16'hFFFF and does not wrap, done=1, pass=0.
- Reset pulsed at T+7 mid-run: all outputs 0 next cycle, FSM in IDLE. A new start yields a full clean run with pass=1.
- start pulsed at T+3 during RUN is ignored and done still rises at T+22. start held high across DONE gives a one-cycle done, a restart, and errcnt cleared to 0.
